// File: rtl/stage_one_arbiter_if.sv
// Requester-side and stage-one-unit-side signals of the stage-one arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface stage_one_arbiter_if #(
   parameter int FLT_DATA_WIDTH      = 32,
   parameter int ACTUAL_CORDIC_WIDTH = 22,
   parameter int NUM_REQ             = 2,
   parameter int ID_WIDTH            = 2
);
   logic                                  clk_en;
   logic [NUM_REQ-1:0]                    req;
   logic [NUM_REQ*FLT_DATA_WIDTH-1:0]     x_in;
   logic [NUM_REQ-1:0]                    grant;
   logic                                  busy;
   logic                                  unit_start;
   logic [FLT_DATA_WIDTH-1:0]             unit_x;
   logic [FLT_DATA_WIDTH-1:0]             unit_half;
   logic [FLT_DATA_WIDTH-1:0]             unit_square;
   logic signed [ACTUAL_CORDIC_WIDTH-1:0] unit_x_to_cordic;
   logic                                  unit_done;
   logic                                  rsp_valid;
   logic [ID_WIDTH-1:0]                   rsp_id;
   logic [FLT_DATA_WIDTH-1:0]             rsp_half;
   logic [FLT_DATA_WIDTH-1:0]             rsp_square;
   logic signed [ACTUAL_CORDIC_WIDTH-1:0] rsp_x_to_cordic;
   logic                                  rsp_err;

   modport slave (
      input  clk_en, req, x_in, unit_half, unit_square, unit_x_to_cordic, unit_done,
      output grant, busy, unit_start, unit_x, rsp_valid, rsp_id, rsp_half, rsp_square,
             rsp_x_to_cordic, rsp_err
   );

   modport master (
      output clk_en, req, x_in, unit_half, unit_square, unit_x_to_cordic, unit_done,
      input  grant, busy, unit_start, unit_x, rsp_valid, rsp_id, rsp_half, rsp_square,
             rsp_x_to_cordic, rsp_err
   );
endinterface

// File: rtl/stage_one_arbiter.sv
// Round-robin arbiter sharing one stage-one unit between NUM_REQ requesters,
// with a watchdog on the unit's done pulse.
//
// state      | meaning
// IDLE       | waiting for clk_en and a request; winner chosen round-robin from ptr
// ISSUE      | unit_start asserted; held until clk_en allows the unit to run
// WAIT       | unit running, watchdog counting; done or watchdog expiry ends it
// RESPOND    | one-cycle rsp_valid; ptr moves past the answered requester
module stage_one_arbiter #(
   parameter int FLT_DATA_WIDTH      = 32,
   parameter int ACTUAL_CORDIC_WIDTH = 22,
   parameter int NUM_REQ             = 2,
   parameter int ID_WIDTH            = 2,
   parameter int COUNTER_WIDTH       = 10,
   parameter logic [COUNTER_WIDTH-1:0] TIMEOUT = 10'd32
) (
   input logic               clk,
   input logic               rst,
   stage_one_arbiter_if.slave bus
);
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;
   localparam logic [1:0] ST_RESPOND = 2'd3;

   localparam logic [COUNTER_WIDTH-1:0] WD_LAST = TIMEOUT - 1'b1;
   localparam logic [ID_WIDTH-1:0]      LAST_ID = ID_WIDTH'(NUM_REQ - 1);

   logic [1:0]                     state_q, state_d;
   logic [ID_WIDTH-1:0]            ptr_q, ptr_d;
   logic [ID_WIDTH-1:0]            cur_id_q, cur_id_d;
   logic [ID_WIDTH-1:0]            rsp_id_q, rsp_id_d;
   logic [COUNTER_WIDTH-1:0]       wd_q, wd_d;
   logic [NUM_REQ-1:0]             grant_q, grant_d;
   logic                           busy_q, busy_d;
   logic                           start_q, start_d;
   logic                           rsp_valid_q, rsp_valid_d;
   logic                           rsp_err_q, rsp_err_d;
   logic [FLT_DATA_WIDTH-1:0]      unit_x_q, unit_x_d;
   logic [FLT_DATA_WIDTH-1:0]      half_q, half_d;
   logic [FLT_DATA_WIDTH-1:0]      square_q, square_d;
   logic [ACTUAL_CORDIC_WIDTH-1:0] cordic_q, cordic_d;

   logic                           hi_found, any_req;
   logic [ID_WIDTH-1:0]            hi_idx, lo_idx, win_idx;
   logic [FLT_DATA_WIDTH-1:0]      win_x;

   // Lowest request at or above ptr wins; otherwise wrap to the lowest request overall.
   always_comb begin : arbitrate
      hi_found = 1'b0;
      any_req  = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            any_req = 1'b1;
            lo_idx  = ID_WIDTH'(i);
            if (ID_WIDTH'(i) >= ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = ID_WIDTH'(i);
            end
         end
      end
      win_idx = hi_found ? hi_idx : lo_idx;
      win_x   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == ID_WIDTH'(i)) win_x = bus.x_in[i*FLT_DATA_WIDTH +: FLT_DATA_WIDTH];
      end
   end

   always_comb begin : next_state
      state_d   = state_q;
      ptr_d     = ptr_q;
      cur_id_d  = cur_id_q;
      rsp_id_d  = rsp_id_q;
      wd_d      = wd_q;
      unit_x_d  = unit_x_q;
      half_d    = half_q;
      square_d  = square_q;
      cordic_d  = cordic_q;
      rsp_err_d = rsp_err_q;
      grant_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.clk_en && any_req) begin
               state_d  = ST_ISSUE;
               cur_id_d = win_idx;
               unit_x_d = win_x;
               grant_d  = NUM_REQ'(1) << win_idx;
            end
         end
         ST_ISSUE: begin
            if (bus.clk_en) begin
               state_d = ST_WAIT;
               wd_d    = '0;
            end
         end
         ST_WAIT: begin
            wd_d = wd_q + 1'b1;
            // done takes priority over a watchdog expiry in the same cycle
            if (bus.unit_done) begin
               state_d   = ST_RESPOND;
               rsp_id_d  = cur_id_q;
               half_d    = bus.unit_half;
               square_d  = bus.unit_square;
               cordic_d  = bus.unit_x_to_cordic;
               rsp_err_d = 1'b0;
            end else if (wd_q == WD_LAST) begin
               state_d   = ST_RESPOND;
               rsp_id_d  = cur_id_q;
               half_d    = '0;
               square_d  = '0;
               cordic_d  = '0;
               rsp_err_d = 1'b1;
            end
         end
         ST_RESPOND: begin
            state_d = ST_IDLE;
            ptr_d   = (rsp_id_q == LAST_ID) ? '0 : rsp_id_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d      = (state_d != ST_IDLE);
      start_d     = (state_d == ST_ISSUE);
      rsp_valid_d = (state_d == ST_RESPOND);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         cur_id_q    <= '0;
         rsp_id_q    <= '0;
         wd_q        <= '0;
         grant_q     <= '0;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         unit_x_q    <= '0;
         half_q      <= '0;
         square_q    <= '0;
         cordic_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cur_id_q    <= cur_id_d;
         rsp_id_q    <= rsp_id_d;
         wd_q        <= wd_d;
         grant_q     <= grant_d;
         busy_q      <= busy_d;
         start_q     <= start_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         unit_x_q    <= unit_x_d;
         half_q      <= half_d;
         square_q    <= square_d;
         cordic_q    <= cordic_d;
      end
   end

   assign bus.grant           = grant_q;
   assign bus.busy            = busy_q;
   assign bus.unit_start      = start_q;
   assign bus.unit_x          = unit_x_q;
   assign bus.rsp_valid       = rsp_valid_q;
   assign bus.rsp_id          = rsp_id_q;
   assign bus.rsp_half        = half_q;
   assign bus.rsp_square      = square_q;
   assign bus.rsp_x_to_cordic = cordic_q;
   assign bus.rsp_err         = rsp_err_q;
endmodule

// File: tb/tb_stage_one_arbiter.sv
// Bench for stage_one_arbiter: a latency-programmable stage-one unit model plus a
// round-robin reference (pointer + first-set-bit search) predicting each response.
module tb_stage_one_arbiter;
   localparam int FW   = 32;
   localparam int CW   = 22;
   localparam int NR   = 2;
   localparam int IW   = 2;
   localparam int CNTW = 10;
   localparam int TO   = 32;

   typedef struct packed {
      int            s_cyc;
      int            g_cyc;
      int            r_cyc;
      logic [NR-1:0] grant;
      logic [NR-1:0] grant_nx;
      logic          start;
      logic          start_nx;
      logic          busy;
      logic [FW-1:0] ux;
      logic [IW-1:0] id;
      logic          err;
      logic [FW-1:0] half;
      logic [FW-1:0] sq;
      logic [CW-1:0] cor;
      logic          valid_nx;
   } obs_t;

   logic          clk;
   logic          rst;
   int            cyc = 0;
   int            vectors = 0;
   int            miscompares = 0;
   int            unit_lat = 4;
   int            m_ptr = 0;
   logic [FW-1:0] xs [NR];

   logic          u_pend = 1'b0;
   int            u_cnt = 0;
   logic [FW-1:0] u_x = '0;

   stage_one_arbiter_if #(.FLT_DATA_WIDTH(FW), .ACTUAL_CORDIC_WIDTH(CW), .NUM_REQ(NR),
                          .ID_WIDTH(IW)) bus ();

   stage_one_arbiter #(.FLT_DATA_WIDTH(FW), .ACTUAL_CORDIC_WIDTH(CW), .NUM_REQ(NR),
                       .ID_WIDTH(IW), .COUNTER_WIDTH(CNTW), .TIMEOUT(10'd32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   function automatic logic [FW-1:0] ref_half(input logic [FW-1:0] x);
      return x - 32'h0080_0000;
   endfunction

   function automatic logic [FW-1:0] ref_square(input logic [FW-1:0] x);
      return x + 32'h0080_0000;
   endfunction

   function automatic logic [CW-1:0] ref_cordic(input logic [FW-1:0] x);
      return x[30:9];
   endfunction

   function automatic int pick(input logic [NR-1:0] mask);
      for (int k = 0; k < NR; k++) begin
         if (mask[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
      end
      return -1;
   endfunction

   // Unit model: runs unit_lat cycles after its last start cycle, done on the cycle after that
   // count; results are garbage except on the done cycle. Negative latency never finishes.
   always @(negedge clk) begin
      bus.unit_done        = 1'b0;
      bus.unit_half        = $urandom;
      bus.unit_square      = $urandom;
      bus.unit_x_to_cordic = CW'($urandom);
      if (bus.unit_start === 1'b1) begin
         u_pend = (unit_lat >= 0);
         u_cnt  = unit_lat + 1;
         u_x    = bus.unit_x;
      end else if (u_pend) begin
         u_cnt--;
         if (u_cnt == 0) begin
            u_pend               = 1'b0;
            bus.unit_done        = 1'b1;
            bus.unit_half        = ref_half(u_x);
            bus.unit_square      = ref_square(u_x);
            bus.unit_x_to_cordic = ref_cordic(u_x);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_x();
      for (int i = 0; i < NR; i++) bus.x_in[i*FW +: FW] = xs[i];
   endtask

   // Presents a request, waits (bounded) for the grant and the response, and records what was seen.
   task automatic serve(input logic [NR-1:0] mask, input int lat, input bit hold, output obs_t o);
      int n;
      o        = '0;
      o.g_cyc  = -1;
      o.r_cyc  = -1;
      unit_lat = lat;
      drive_x();
      bus.req  = mask;
      o.s_cyc  = cyc;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.grant === '0 && n < 8);
      if (bus.grant !== '0) begin
         o.g_cyc = cyc;
         o.grant = bus.grant;
         o.start = bus.unit_start;
         o.busy  = bus.busy;
         o.ux    = bus.unit_x;
         if (!hold) bus.req = '0;
         tick();
         o.grant_nx = bus.grant;
         o.start_nx = bus.unit_start;
         n = 0;
         while (bus.rsp_valid !== 1'b1 && n < TO + 16) begin
            tick();
            n++;
         end
         if (bus.rsp_valid === 1'b1) begin
            o.r_cyc = cyc;
            o.id    = bus.rsp_id;
            o.err   = bus.rsp_err;
            o.half  = bus.rsp_half;
            o.sq    = bus.rsp_square;
            o.cor   = bus.rsp_x_to_cordic;
         end
         tick();
         o.valid_nx = bus.rsp_valid;
      end else begin
         bus.req = '0;
      end
   endtask

   task automatic test_reset();
      bus.req = 2'b01;
      repeat (3) tick();
      vectors++;
      if ({bus.grant, bus.busy, bus.unit_start, bus.unit_x, bus.rsp_valid, bus.rsp_id, bus.rsp_half,
           bus.rsp_square, bus.rsp_x_to_cordic, bus.rsp_err} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got grant=%b busy=%b start=%b unit_x=%h rsp_valid=%b, want all 0",
                  bus.grant, bus.busy, bus.unit_start, bus.unit_x, bus.rsp_valid);
      end
      bus.req = '0;
      tick();
      rst = 1'b1;
      repeat (2) tick();
      vectors++;
      if ({bus.grant, bus.busy, bus.rsp_valid} !== '0) begin
         miscompares++;
         $display("FAIL idle_after_reset: got grant=%b busy=%b rsp_valid=%b, want 0 0 0",
                  bus.grant, bus.busy, bus.rsp_valid);
      end
      m_ptr = 0;
   endtask

   task automatic test_contention();
      obs_t o;
      int   prev_r;
      int   w;
      xs[0] = 32'h3FC0_0000;
      xs[1] = 32'hC120_0000;
      prev_r = -1;
      for (int k = 0; k < 4; k++) begin
         w = k % 2;
         serve(2'b11, 2 + k, (k < 3), o);
         vectors++;
         if (o.grant !== NR'(1 << w)) begin
            miscompares++;
            $display("FAIL contention_grant[%0d]: got %b, want %b", k, o.grant, NR'(1 << w));
         end
         vectors++;
         if (o.id !== IW'(w) || o.err !== 1'b0) begin
            miscompares++;
            $display("FAIL contention_id[%0d]: got id=%0d err=%b, want id=%0d err=0", k, o.id, o.err, w);
         end
         vectors++;
         if (o.half !== ref_half(xs[w]) || o.sq !== ref_square(xs[w])) begin
            miscompares++;
            $display("FAIL contention_data[%0d]: got %h/%h, want %h/%h", k, o.half, o.sq,
                     ref_half(xs[w]), ref_square(xs[w]));
         end
         if (k > 0) begin
            vectors++;
            if (o.g_cyc - prev_r !== 2) begin
               miscompares++;
               $display("FAIL contention_gap[%0d]: got %0d cycles rsp->grant, want 2", k, o.g_cyc - prev_r);
            end
         end
         prev_r = o.r_cyc;
         m_ptr  = (w + 1) % NR;
      end
   endtask

   task automatic test_single();
      obs_t o;
      xs[0] = 32'h4000_0000;
      xs[1] = 32'h0000_0000;
      serve(2'b01, 6, 1'b0, o);
      vectors++;
      if (o.grant !== 2'b01 || o.g_cyc - o.s_cyc !== 1) begin
         miscompares++;
         $display("FAIL single_grant: got %b after %0d cycles, want 01 after 1", o.grant, o.g_cyc - o.s_cyc);
      end
      vectors++;
      if ({o.start, o.busy, o.grant_nx, o.start_nx} !== 5'b11_00_0) begin
         miscompares++;
         $display("FAIL single_pulses: got start=%b busy=%b grant_nx=%b start_nx=%b, want 1 1 00 0",
                  o.start, o.busy, o.grant_nx, o.start_nx);
      end
      vectors++;
      if (o.ux !== 32'h4000_0000) begin
         miscompares++;
         $display("FAIL single_unit_x: got %h, want 40000000", o.ux);
      end
      vectors++;
      if (o.r_cyc - o.g_cyc !== 8) begin
         miscompares++;
         $display("FAIL single_latency: got %0d, want 8", o.r_cyc - o.g_cyc);
      end
      vectors++;
      if ({o.id, o.err, o.half, o.sq, o.cor} !== {2'd0, 1'b0, 32'h3F80_0000, 32'h4080_0000,
                                                    ref_cordic(32'h4000_0000)}) begin
         miscompares++;
         $display("FAIL single_rsp: got id=%0d err=%b half=%h sq=%h cor=%h, want 0 0 3f800000 40800000 %h",
                  o.id, o.err, o.half, o.sq, o.cor, ref_cordic(32'h4000_0000));
      end
      vectors++;
      if (o.valid_nx !== 1'b0) begin
         miscompares++;
         $display("FAIL single_valid_pulse: got %b, want 0", o.valid_nx);
      end
      m_ptr = 1;
   endtask

   task automatic test_watchdog();
      obs_t o;
      xs[0] = 32'h4110_0000;
      xs[1] = 32'h3E80_0000;
      serve(2'b01, -1, 1'b0, o);
      vectors++;
      if (o.grant !== 2'b01 || o.r_cyc - o.g_cyc !== TO + 1) begin
         miscompares++;
         $display("FAIL watchdog_timing: got grant=%b after %0d cycles, want 01 after %0d",
                  o.grant, o.r_cyc - o.g_cyc, TO + 1);
      end
      vectors++;
      if ({o.id, o.err, o.half, o.sq, o.cor} !== {2'd0, 1'b1, 86'd0}) begin
         miscompares++;
         $display("FAIL watchdog_rsp: got id=%0d err=%b half=%h sq=%h cor=%h, want 0 1 0 0 0",
                  o.id, o.err, o.half, o.sq, o.cor);
      end
      m_ptr = 1;
      serve(2'b11, 2, 1'b0, o);
      vectors++;
      if (o.grant !== 2'b10 || o.id !== 2'd1 || o.err !== 1'b0) begin
         miscompares++;
         $display("FAIL watchdog_ptr: got grant=%b id=%0d err=%b, want 10 1 0", o.grant, o.id, o.err);
      end
      m_ptr = 0;
   endtask

   task automatic test_clk_en();
      int s_cyc;
      int r_cyc;
      int n_rsp;
      int n_start;
      logic [IW-1:0] id;
      logic [FW-1:0] half;
      xs[1] = $urandom;
      drive_x();
      bus.clk_en = 1'b0;
      bus.req    = 2'b10;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if ({bus.grant, bus.busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL clk_en_idle[%0d]: got grant=%b busy=%b, want 00 0", i, bus.grant, bus.busy);
         end
      end
      unit_lat   = 4;
      bus.clk_en = 1'b1;
      tick();
      vectors++;
      if (bus.grant !== 2'b10 || bus.unit_start !== 1'b1) begin
         miscompares++;
         $display("FAIL clk_en_grant: got grant=%b start=%b, want 10 1", bus.grant, bus.unit_start);
      end
      bus.clk_en = 1'b0;
      bus.req    = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({bus.unit_start, bus.grant, bus.busy} !== 4'b1001) begin
            miscompares++;
            $display("FAIL clk_en_hold[%0d]: got start=%b grant=%b busy=%b, want 1 00 1",
                     i, bus.unit_start, bus.grant, bus.busy);
         end
      end
      s_cyc      = cyc;
      bus.clk_en = 1'b1;
      n_rsp   = 0;
      n_start = 0;
      r_cyc   = -1;
      id      = '0;
      half    = '0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.unit_start === 1'b1) n_start++;
         if (bus.rsp_valid === 1'b1) begin
            n_rsp++;
            if (r_cyc < 0) begin
               r_cyc = cyc;
               id    = bus.rsp_id;
               half  = bus.rsp_half;
            end
         end
      end
      vectors++;
      if (n_rsp !== 1 || n_start !== 0) begin
         miscompares++;
         $display("FAIL clk_en_once: got %0d responses %0d extra starts, want 1 and 0", n_rsp, n_start);
      end
      vectors++;
      if (r_cyc - s_cyc !== 6 || id !== 2'd1 || half !== ref_half(xs[1])) begin
         miscompares++;
         $display("FAIL clk_en_rsp: got latency=%0d id=%0d half=%h, want 6 1 %h",
                  r_cyc - s_cyc, id, half, ref_half(xs[1]));
      end
      m_ptr = 0;
   endtask

   task automatic test_reset_mid_wait();
      obs_t o;
      int   n_bad;
      xs[0] = 32'h4040_0000;
      xs[1] = $urandom;
      drive_x();
      unit_lat = 20;
      bus.req  = 2'b10;
      tick();
      vectors++;
      if (bus.grant !== 2'b10) begin
         miscompares++;
         $display("FAIL rst_wait_grant: got %b, want 10", bus.grant);
      end
      bus.req = '0;
      repeat (5) tick();
      rst = 1'b0;
      #1;
      vectors++;
      if ({bus.grant, bus.busy, bus.unit_start, bus.unit_x, bus.rsp_valid, bus.rsp_id, bus.rsp_half,
           bus.rsp_square, bus.rsp_x_to_cordic, bus.rsp_err} !== '0) begin
         miscompares++;
         $display("FAIL rst_wait_async: got busy=%b unit_x=%h rsp_half=%h, want all outputs 0",
                  bus.busy, bus.unit_x, bus.rsp_half);
      end
      repeat (2) tick();
      rst   = 1'b1;
      m_ptr = 0;
      n_bad = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) n_bad++;
      end
      vectors++;
      if (n_bad !== 0) begin
         miscompares++;
         $display("FAIL rst_wait_late_done: got %0d cycles with rsp_valid/busy set, want 0", n_bad);
      end
      serve(2'b11, 3, 1'b0, o);
      vectors++;
      if (o.grant !== 2'b01 || o.id !== 2'd0 || o.half !== ref_half(xs[0])) begin
         miscompares++;
         $display("FAIL rst_wait_next: got grant=%b id=%0d half=%h, want 01 0 %h",
                  o.grant, o.id, o.half, ref_half(xs[0]));
      end
      m_ptr = 1;
   endtask

   task automatic test_done_at_timeout();
      obs_t o;
      xs[0] = 32'h4280_0000;
      xs[1] = 32'h3D00_0000;
      serve(2'b01, TO - 1, 1'b0, o);
      vectors++;
      if (o.r_cyc - o.g_cyc !== TO + 1 || o.err !== 1'b0 || o.id !== 2'd0) begin
         miscompares++;
         $display("FAIL done_at_timeout: got latency=%0d err=%b id=%0d, want %0d 0 0",
                  o.r_cyc - o.g_cyc, o.err, o.id, TO + 1);
      end
      vectors++;
      if ({o.half, o.sq, o.cor} !== {ref_half(xs[0]), ref_square(xs[0]), ref_cordic(xs[0])}) begin
         miscompares++;
         $display("FAIL done_at_timeout_data: got %h/%h/%h, want %h/%h/%h", o.half, o.sq, o.cor,
                  ref_half(xs[0]), ref_square(xs[0]), ref_cordic(xs[0]));
      end
      m_ptr = 1;
      serve(2'b10, TO, 1'b0, o);
      vectors++;
      if (o.r_cyc - o.g_cyc !== TO + 1 || o.err !== 1'b1 || o.id !== 2'd1 || o.half !== '0) begin
         miscompares++;
         $display("FAIL done_after_timeout: got latency=%0d err=%b id=%0d half=%h, want %0d 1 1 0",
                  o.r_cyc - o.g_cyc, o.err, o.id, o.half, TO + 1);
      end
      m_ptr = 0;
   endtask

   task automatic test_random();
      obs_t          o;
      logic [NR-1:0] mask;
      int            lat;
      int            sel;
      int            w;
      bit            err;
      int            lat_exp;
      for (int k = 0; k < 16; k++) begin
         mask = NR'($urandom_range(1, 3));
         for (int i = 0; i < NR; i++) xs[i] = $urandom;
         sel = $urandom_range(0, 9);
         if (sel < 6)       lat = $urandom_range(1, 12);
         else if (sel == 6) lat = TO - 1;
         else if (sel == 7) lat = TO;
         else if (sel == 8) lat = TO + 8;
         else               lat = -1;
         w       = pick(mask);
         err     = (lat < 0) || (lat > TO - 1);
         lat_exp = err ? TO + 1 : lat + 2;
         serve(mask, lat, $urandom_range(0, 1) == 1, o);
         vectors++;
         if (o.grant !== NR'(1 << w) || o.g_cyc - o.s_cyc !== 1) begin
            miscompares++;
            $display("FAIL random_grant[%0d]: got %b after %0d, want %b after 1 (req=%b)",
                     k, o.grant, o.g_cyc - o.s_cyc, NR'(1 << w), mask);
         end
         vectors++;
         if (o.r_cyc - o.g_cyc !== lat_exp || o.id !== IW'(w) || o.err !== err) begin
            miscompares++;
            $display("FAIL random_rsp[%0d]: got latency=%0d id=%0d err=%b, want %0d %0d %b (lat=%0d)",
                     k, o.r_cyc - o.g_cyc, o.id, o.err, lat_exp, w, err, lat);
         end
         vectors++;
         if (err ? ({o.half, o.sq, o.cor} !== '0)
                 : ({o.half, o.sq, o.cor} !== {ref_half(xs[w]), ref_square(xs[w]), ref_cordic(xs[w])})) begin
            miscompares++;
            $display("FAIL random_data[%0d]: got %h/%h/%h, err expected %b", k, o.half, o.sq, o.cor, err);
         end
         m_ptr = (w + 1) % NR;
      end
   endtask

   initial begin
      rst                  = 1'b0;
      bus.clk_en           = 1'b1;
      bus.req              = '0;
      bus.x_in             = '0;
      bus.unit_done        = 1'b0;
      bus.unit_half        = '0;
      bus.unit_square      = '0;
      bus.unit_x_to_cordic = '0;
      for (int i = 0; i < NR; i++) xs[i] = '0;
      test_reset();
      test_contention();
      test_single();
      test_watchdog();
      test_clk_en();
      test_reset_mid_wait();
      test_done_at_timeout();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
